// File: rtl/varint_pkg.sv
// Shared definitions for the varint serializer/deserializer family:
// encoded-length helper, 64-bit ZigZag reference and the encoded byte layout.
package varint_pkg;

  function automatic int varint_max_bytes(input int w);
    return (w + 6) / 7;
  endfunction

  function automatic logic [63:0] zigzag64(input logic [63:0] v);
    return (v << 1) ^ {64{v[63]}};
  endfunction

  typedef struct packed {
    logic       cont;
    logic [6:0] payload;
  } varint_byte_t;

endpackage

// File: rtl/varint_zigzag.sv
// Combinational ZigZag transform (sint mapping), shared by encoder and decoder.
module varint_zigzag #(
  parameter int DATA_W = 64
) (
  input  logic [DATA_W-1:0] data,
  output logic [DATA_W-1:0] zz
);

  // Arithmetic sign smeared across the word folds negatives onto odd codes.
  assign zz = (data << 1) ^ {DATA_W{data[DATA_W-1]}};

endmodule

// File: rtl/varint_stream_enc.sv
// Streaming protobuf base-128 varint encoder: one integer in per handshake,
// one encoded byte out per cycle, optional ZigZag pre-transform.
module varint_stream_enc
  import varint_pkg::*;
#(
  parameter int DATA_W    = 64,
  parameter int MAX_BYTES = varint_max_bytes(DATA_W)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [DATA_W-1:0]            in_data,
  input  logic                         in_zigzag,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [7:0]                   out_byte,
  output logic                         out_last,
  output logic [$clog2(MAX_BYTES)-1:0] out_idx
);

  localparam int IDX_W = $clog2(MAX_BYTES);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] EMIT = 1'b1;

  logic [0:0]        state;
  logic [DATA_W-1:0] val;
  logic [DATA_W-1:0] zz_data;
  logic              more;
  logic              accept;
  logic              consume;
  varint_byte_t      cur;

  varint_zigzag #(
    .DATA_W(DATA_W)
  ) u_zigzag (
    .data(in_data),
    .zz  (zz_data)
  );

  assign more    = |val[DATA_W-1:7];
  assign consume = out_valid && out_ready;
  assign accept  = in_valid && in_ready;

  always_comb begin
    cur.cont    = more;
    cur.payload = val[6:0];
  end

  // Outputs are forced quiet outside EMIT so the idle bus reads as all-zero.
  assign out_valid = (state == EMIT);
  assign out_byte  = out_valid ? cur : 8'h00;
  assign out_last  = out_valid && !more;

  // Ready can come from the final-byte consume so varints stream with no bubble.
  assign in_ready = !rst && ((state == IDLE) || (consume && out_last));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      val     <= '0;
      out_idx <= '0;
    end else if (accept) begin
      state   <= EMIT;
      val     <= in_zigzag ? zz_data : in_data;
      out_idx <= '0;
    end else if (consume) begin
      if (more) begin
        val     <= val >> 7;
        out_idx <= out_idx + IDX_W'(1);
      end else begin
        state <= IDLE;
      end
    end
  end

endmodule

// File: doc/varint_stream_enc.md
# varint_stream_enc

Sequential, parametrised successor to the combinational `varint_ser`. It accepts one integer per handshake and emits its protobuf base-128 varint encoding one byte per cycle on a valid/ready byte stream, with an optional ZigZag (sint) mode. It sits between the field-value datapath and the message byte packer in the serializer pipeline.

## Interface

Parameters:
- `DATA_W`, default 64. Input integer width. Legal values are 32 and 64.
- `MAX_BYTES`, default `(DATA_W+6)/7`. Maximum encoded length: 10 when `DATA_W`=64, 5 when `DATA_W`=32. Derived; do not override.

Ports:
- `clk`, input, 1. Single clock. All logic is rising-edge.
- `rst`, input, 1. Reset: asynchronous, active-high.
- `in_valid`, input, 1. Input value offered.
- `in_ready`, output, 1. Block can accept a value.
- `in_data`, input, `DATA_W`. Integer to encode, two's complement.
- `in_zigzag`, input, 1. 1 means apply the ZigZag transform before encoding. Sampled together with `in_data`.
- `out_valid`, output, 1. `out_byte` is valid.
- `out_ready`, input, 1. Downstream accepts the byte.
- `out_byte`, output, 8. Encoded byte: bit 7 is the continuation flag, bits 6:0 are the payload.
- `out_last`, output, 1. Marks the final byte of the current varint.
- `out_idx`, output, `$clog2(MAX_BYTES)`. Index of the current byte within its varint, starting at 0.

## Operation

- The FSM has two states, IDLE and EMIT.
- **Accept:** a value is accepted on a cycle where `in_valid && in_ready`.
- **Latch:** on accept, the shift register `val` ← `in_zigzag ? ((in_data<<1) ^ {DATA_W{in_data[DATA_W-1]}}) : in_data`. Then `out_idx`←0 and the state goes to EMIT.
- **Byte generation in EMIT:**
  - `more = |val[DATA_W-1:7]`
  - `out_byte = {more, val[6:0]}`
  - `out_last = ~more`
  - `out_valid = 1`
- **Consume:** on `out_valid && out_ready`:
  - If `more`: `val` ← `val>>7` (logical shift), `out_idx`+1, stay in EMIT.
  - Else: return to IDLE, unless a new value is accepted in the same cycle.
- **`in_ready`:** `in_ready = !rst && (state==IDLE || (out_valid && out_ready && out_last))`. This is a combinational path from `out_ready` to `in_ready` and is intentional; it gives back-to-back throughput.
- **Negatives without ZigZag:** the value is encoded as an unsigned `DATA_W`-bit quantity. With `DATA_W`=64, -1 encodes to 10 bytes. No sign extension is performed when `DATA_W`=32.
- **Zero:** encodes to the single byte 0x00 with `out_last`=1.
- **Length bound:** the encoded length never exceeds `MAX_BYTES`. `out_idx` never exceeds `MAX_BYTES-1`.

## Timing

- **Reset values:**
  - state = IDLE
  - `out_valid`=0, `out_byte`=0, `out_last`=0, `out_idx`=0
  - `in_ready`=0 while `rst` is high, 1 in the first cycle after release
- **Latency:** the first byte is valid in the cycle after acceptance. Output is registered state; `out_byte` and `out_last` decode combinationally from `val`.
- **Throughput:** one byte per cycle when `out_ready`=1. An N-byte varint occupies exactly N output cycles with no bubble between consecutive varints.
- **Backpressure:** while `out_valid && !out_ready`, `out_byte`, `out_last` and `out_idx` hold stable and `in_ready`=0.
- **Downstream rule:** `out_valid` never drops without a handshake.
- **Upstream freedom:** `in_valid` may toggle freely while `in_ready`=0. `in_data` is ignored when no handshake occurs.
- **Simultaneous last-byte consume and new accept:** the new value is loaded, `out_idx`←0, and the state stays in EMIT.
- **Reset mid-varint:** the remaining bytes are discarded. The next accept starts cleanly at `out_idx`=0.

## Structure

- Shared package `varint_pkg`:
  - `localparam` function `varint_max_bytes(int w)`
  - function `zigzag64(logic [63:0])`
  - typedef `varint_byte_t` (packed struct `{logic cont; logic [6:0] payload;}`)
- One sub-module, `varint_zigzag`: a combinational ZigZag transform parametrised by `DATA_W`, reused later by the deserializer.
- Top level contains the FSM, the `val` shift register and the `out_idx` counter. Expected size is about 150–250 lines.

## Test plan

- **Basic encode:** 150, zigzag=0, `out_ready`=1 → 0x96 (idx 0), 0x01 (idx 1, last); `in_ready` high during the last byte.
- **Zero:** 0 → single 0x00 with `out_last`=1. Then 300 accepted back-to-back → 0xAC, 0x02 with no idle cycle.
- **ZigZag:** zigzag=1 with -1 → 0x01; with 1 → 0x02; with -64 → 0x7F; with 64 → 0x80, 0x01.
- **Negative, no ZigZag:** `DATA_W`=64, zigzag=0, -1 → nine 0xFF then 0x01 (idx 9, last). `DATA_W`=32, 0xFFFFFFFF → 0xFF×4 then 0x0F.
- **Backpressure:** 150 with `out_ready` low for 3 cycles after the first byte → 0x96 held stable with `in_ready`=0, then 0x01 follows once `out_ready` rises.
- **Reset mid-varint:** assert `rst` after the first byte of 300 → `out_valid`=0 immediately. After release, encoding 1 yields 0x01 at idx 0.
